// File: rtl/calc_stream_controller.sv
`default_nettype none
// ============================================================================
// Module : calc_stream_controller
// Brief  : Streams packed operand pairs from SRAM, applies add/sub per mode
//          and writes two packed results per memory word back over a window.
// Rev    : 1.0
// ============================================================================
module calc_stream_controller #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [1:0]          mode_i,
  input  logic [ADDR_W-1:0]   read_start_addr,
  input  logic [ADDR_W-1:0]   read_end_addr,
  input  logic [ADDR_W-1:0]   write_start_addr,
  input  logic [ADDR_W-1:0]   write_end_addr,
  output logic                read,
  output logic [ADDR_W-1:0]   r_addr,
  input  logic [2*DATA_W-1:0] r_data,
  output logic                write,
  output logic [ADDR_W-1:0]   w_addr,
  output logic [2*DATA_W-1:0] w_data,
  output logic                busy_o,
  output logic                done_o,
  output logic                ovf_o,
  output logic                err_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // WAIT spans RD_LAT-1 cycles, so the counter exits at RD_LAT-2.
  localparam logic [1:0] c_wait_last = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  logic [2:0]          r_state;
  logic [2:0]          w_next_state;
  logic [ADDR_W-1:0]   r_raddr;
  logic [ADDR_W-1:0]   r_waddr;
  logic [ADDR_W-1:0]   r_rend;
  logic [ADDR_W-1:0]   r_wend;
  logic [1:0]          r_mode;
  logic                r_half;
  logic                r_last;
  logic [2*DATA_W-1:0] r_buf;
  logic [1:0]          r_wait_cnt;
  logic                r_ovf;
  logic                r_err;

  logic                w_start_bad;
  logic                w_at_rend;
  logic                w_at_wend;
  logic [DATA_W-1:0]   w_a;
  logic [DATA_W-1:0]   w_b;
  logic [DATA_W:0]     w_res;

  assign w_start_bad = (read_end_addr < read_start_addr) ||
                       (write_end_addr < write_start_addr);
  assign w_at_rend   = (r_raddr == r_rend);
  assign w_at_wend   = (r_waddr == r_wend);
  assign w_a         = r_data[2*DATA_W-1:DATA_W];
  assign w_b         = r_data[DATA_W-1:0];

  // The extra MSB is the carry for add modes and the borrow for sub modes.
  always_comb begin
    w_res = '0;
    case (r_mode)
      2'b00:   w_res = {1'b0, w_a} + {1'b0, w_b};
      2'b01:   w_res = {1'b0, w_a} - {1'b0, w_b};
      2'b10:   w_res = {1'b0, w_b} - {1'b0, w_a};
      default: w_res = {1'b0, w_a} + {1'b0, w_b} + {{DATA_W{1'b0}}, 1'b1};
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start_i) w_next_state = w_start_bad ? S_DONE : S_READ;
      end
      S_READ: begin
        if (RD_LAT > 1) w_next_state = S_WAIT;
        else            w_next_state = S_EXEC;
      end
      S_WAIT: begin
        if (r_wait_cnt == c_wait_last) w_next_state = S_EXEC;
      end
      S_EXEC: begin
        if (r_half || w_at_rend) w_next_state = S_WRITE;
        else                     w_next_state = S_READ;
      end
      S_WRITE: begin
        if (r_last || w_at_wend) w_next_state = S_DONE;
        else                     w_next_state = S_READ;
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    read   = 1'b1;
    write  = 1'b1;
    busy_o = 1'b0;
    done_o = 1'b0;
    case (r_state)
      S_READ:  begin read  = 1'b0; busy_o = 1'b1; end
      S_WAIT:  busy_o = 1'b1;
      S_EXEC:  busy_o = 1'b1;
      S_WRITE: begin write = 1'b0; busy_o = 1'b1; end
      S_DONE:  done_o = 1'b1;
      default: ;
    endcase
  end

  assign r_addr = r_raddr;
  assign w_addr = r_waddr;
  assign w_data = r_buf;
  assign ovf_o  = r_ovf;
  assign err_o  = r_err;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_raddr    <= '0;
      r_waddr    <= '0;
      r_rend     <= '0;
      r_wend     <= '0;
      r_mode     <= '0;
      r_half     <= 1'b0;
      r_last     <= 1'b0;
      r_buf      <= '0;
      r_wait_cnt <= '0;
      r_ovf      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_ovf   <= 1'b0;
            r_err   <= w_start_bad;
            r_mode  <= mode_i;
            r_raddr <= read_start_addr;
            r_rend  <= read_end_addr;
            r_waddr <= write_start_addr;
            r_wend  <= write_end_addr;
            r_half  <= 1'b0;
            r_last  <= 1'b0;
            r_buf   <= '0;
          end
        end
        S_READ: r_wait_cnt <= '0;
        S_WAIT: r_wait_cnt <= r_wait_cnt + 2'd1;
        S_EXEC: begin
          r_ovf <= r_ovf | w_res[DATA_W];
          if (r_half) r_buf[2*DATA_W-1:DATA_W] <= w_res[DATA_W-1:0];
          else        r_buf[DATA_W-1:0]        <= w_res[DATA_W-1:0];
          r_half <= ~r_half;
          if (w_at_rend) r_last  <= 1'b1;
          else           r_raddr <= r_raddr + 1'b1;
        end
        S_WRITE: begin
          // Clearing here leaves the upper half zero after an odd final word.
          if (!(r_last || w_at_wend)) begin
            r_waddr <= r_waddr + 1'b1;
            r_buf   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_calc_stream_controller.sv
`default_nettype none
// ============================================================================
// Module : tb_calc_stream_controller
// Brief  : Directed bench for calc_stream_controller at RD_LAT=1 and RD_LAT=3.
// Rev    : 1.0
// ============================================================================
module tb_calc_stream_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start1 = 1'b0;
  logic        start3 = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [8:0]  rs = '0, re = '0, ws = '0, we = '0;

  logic        read1, write1, busy1, done1, ovf1, err1;
  logic [8:0]  raddr1, waddr1;
  logic [63:0] rdata1, wdata1;
  logic        read3, write3, busy3, done3, ovf3, err3;
  logic [8:0]  raddr3, waddr3;
  logic [63:0] rdata3, wdata3;

  logic [63:0] rmem [0:15];
  logic [63:0] p0, p1, p2;

  logic        clr_log = 1'b0;
  int          rd_cnt, wr_cnt, done_cnt, overlap;
  logic        prev_wr;
  logic [8:0]  wlog_a [0:7];
  logic [63:0] wlog_d [0:7];

  int checks = 0;
  int fails  = 0;
  int cyc;
  bit ok;

  always #5 clk = ~clk;

  calc_stream_controller #(.ADDR_W(9), .DATA_W(32), .RD_LAT(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .mode_i(mode),
    .read_start_addr(rs), .read_end_addr(re),
    .write_start_addr(ws), .write_end_addr(we),
    .read(read1), .r_addr(raddr1), .r_data(rdata1),
    .write(write1), .w_addr(waddr1), .w_data(wdata1),
    .busy_o(busy1), .done_o(done1), .ovf_o(ovf1), .err_o(err1));

  calc_stream_controller #(.ADDR_W(9), .DATA_W(32), .RD_LAT(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .start_i(start3), .mode_i(mode),
    .read_start_addr(rs), .read_end_addr(re),
    .write_start_addr(ws), .write_end_addr(we),
    .read(read3), .r_addr(raddr3), .r_data(rdata3),
    .write(write3), .w_addr(waddr3), .w_data(wdata3),
    .busy_o(busy3), .done_o(done3), .ovf_o(ovf3), .err_o(err3));

  // SRAM read ports: one-cycle for dut1, three-stage pipe for dut3.
  always @(posedge clk) begin
    if (!read1) rdata1 <= rmem[raddr1[3:0]];
    if (!read3) p0 <= rmem[raddr3[3:0]];
    p1 <= p0;
    p2 <= p1;
  end
  assign rdata3 = p2;

  always @(posedge clk) begin
    if (clr_log) begin
      rd_cnt <= 0; wr_cnt <= 0; done_cnt <= 0; overlap <= 0; prev_wr <= 1'b0;
    end else begin
      if (!read1 || !read3) rd_cnt <= rd_cnt + 1;
      if (!write1) begin
        wlog_a[wr_cnt[2:0]] <= waddr1; wlog_d[wr_cnt[2:0]] <= wdata1; wr_cnt <= wr_cnt + 1;
      end else if (!write3) begin
        wlog_a[wr_cnt[2:0]] <= waddr3; wlog_d[wr_cnt[2:0]] <= wdata3; wr_cnt <= wr_cnt + 1;
      end
      if (done1 || done3) done_cnt <= done_cnt + 1;
      if ((!read1 && !write1) || (!read3 && !write3)) overlap <= overlap + 1;
      prev_wr <= !write1 || !write3;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    clr_log = 1'b1;
    @(negedge clk);
    clr_log = 1'b0;
  endtask

  // Returns at the negedge of the first cycle after the accepting edge.
  task automatic kick(input bit which, input logic [8:0] a, input logic [8:0] b,
                      input logic [8:0] c, input logic [8:0] d, input logic [1:0] m);
    @(negedge clk);
    rs = a; re = b; ws = c; we = d; mode = m;
    if (which) start3 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start3 = 1'b0;
    rs = 9'h1ff; re = '0; ws = 9'h1ff; we = '0; mode = 2'b11;
  endtask

  task automatic wait_done(input bit which, output int n, output bit found);
    n = 1;
    while (!(which ? done3 : done1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    found = which ? done3 : done1;
  endtask

  task automatic run1(input string tag, input logic [8:0] a, input logic [8:0] b,
                      input logic [8:0] c, input logic [8:0] d, input logic [1:0] m,
                      input logic [63:0] exp_w, input logic exp_ovf);
    clear_log();
    kick(1'b0, a, b, c, d, m);
    wait_done(1'b0, cyc, ok);
    check({tag, "_done"}, ok, 1'b1);
    check({tag, "_ovf"}, ovf1, exp_ovf);
    @(negedge clk);
    check({tag, "_wdata"}, wlog_d[0], exp_w);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rmem[i] = '0;
    rmem[0] = {32'd1, 32'd2};
    rmem[1] = {32'd3, 32'd4};
    rmem[2] = {32'd5, 32'd6};
    rmem[3] = {32'd7, 32'd8};
    rmem[8] = {32'hFFFF_FFFF, 32'd2};
    for (int i = 4; i < 8; i++) rmem[i] = {32'(i), 32'(i)};

    clr_log = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_read",  read1,  1'b1);
    check("rst_write", write1, 1'b1);
    check("rst_flags", {busy1, done1, ovf1, err1}, 4'b0000);
    check("rst_addr",  {raddr1, waddr1}, 18'd0);
    check("rst_wdata", wdata1, 64'd0);
    rst = 1'b0;
    clr_log = 1'b0;
    @(negedge clk);
    check("post_rst_strobes", {read1, write1, read3, write3}, 4'b1111);

    // Add mode, four words into two result words
    clear_log();
    kick(1'b0, 9'd0, 9'd3, 9'd10, 9'd11, 2'b00);
    check("t1_busy", busy1, 1'b1);
    wait_done(1'b0, cyc, ok);
    check("t1_done", ok, 1'b1);
    check("t1_latency", cyc, 11);
    check("t1_ovf", ovf1, 1'b0);
    @(negedge clk);
    check("t1_counts", {8'(rd_cnt), 8'(wr_cnt), 8'(done_cnt)}, {8'd4, 8'd2, 8'd1});
    check("t1_w0", {wlog_a[0], wlog_d[0]}, {9'd10, 32'd7, 32'd3});
    check("t1_w1", {wlog_a[1], wlog_d[1]}, {9'd11, 32'd15, 32'd11});

    // Odd operand count leaves the upper half zero
    clear_log();
    kick(1'b0, 9'd0, 9'd2, 9'd10, 9'd12, 2'b00);
    wait_done(1'b0, cyc, ok);
    check("t2_done", ok, 1'b1);
    check("t2_done_after_write", prev_wr, 1'b1);
    check("t2_wr_before_done", wr_cnt, 2);
    @(negedge clk);
    check("t2_counts", {8'(rd_cnt), 8'(wr_cnt), 8'(done_cnt)}, {8'd3, 8'd2, 8'd1});
    check("t2_w1", {wlog_a[1], wlog_d[1]}, {9'd11, 32'd0, 32'd11});

    // One-word run latency
    clear_log();
    kick(1'b0, 9'd0, 9'd0, 9'd10, 9'd10, 2'b00);
    wait_done(1'b0, cyc, ok);
    check("lat1_done", ok, 1'b1);
    check("lat1_cycles", cyc, 4);

    // Subtraction with borrow, then ovf sticky until next start
    run1("t3_sub", 9'd0, 9'd0, 9'd12, 9'd12, 2'b01, {32'd0, 32'hFFFF_FFFF}, 1'b1);
    repeat (2) @(negedge clk);
    check("t3_ovf_sticky", ovf1, 1'b1);

    // Write window shorter than the read window
    clear_log();
    kick(1'b0, 9'd0, 9'd7, 9'd20, 9'd20, 2'b00);
    check("t4_ovf_cleared", ovf1, 1'b0);
    wait_done(1'b0, cyc, ok);
    check("t4_done", ok, 1'b1);
    @(negedge clk);
    check("t4_counts", {8'(rd_cnt), 8'(wr_cnt), 8'(done_cnt)}, {8'd2, 8'd1, 8'd1});
    check("t4_w0", {wlog_a[0], wlog_d[0]}, {9'd20, 32'd7, 32'd3});

    run1("m10", 9'd1, 9'd1, 9'd13, 9'd13, 2'b10, {32'd0, 32'd1}, 1'b0);
    run1("m11", 9'd2, 9'd2, 9'd13, 9'd13, 2'b11, {32'd0, 32'd12}, 1'b0);
    run1("m00_carry", 9'd8, 9'd8, 9'd14, 9'd14, 2'b00, {32'd0, 32'd1}, 1'b1);
    run1("m10_borrow", 9'd8, 9'd8, 9'd14, 9'd14, 2'b10, {32'd0, 32'h0000_0003}, 1'b1);

    // Rejected starts: reversed read window, then reversed write window
    clear_log();
    kick(1'b0, 9'd5, 9'd4, 9'd10, 9'd10, 2'b00);
    check("t5_done", done1, 1'b1);
    check("t5_err_busy", {err1, busy1}, 2'b10);
    repeat (2) @(negedge clk);
    check("t5_counts", {8'(rd_cnt), 8'(wr_cnt), 8'(done_cnt)}, {8'd0, 8'd0, 8'd1});
    check("t5_err_sticky", err1, 1'b1);
    kick(1'b0, 9'd0, 9'd0, 9'd11, 9'd10, 2'b00);
    check("t5w_err", {done1, err1}, 2'b11);
    @(negedge clk);
    kick(1'b0, 9'd0, 9'd0, 9'd10, 9'd10, 2'b00);
    check("t5_err_cleared", err1, 1'b0);
    wait_done(1'b0, cyc, ok);
    check("t5_good_done", ok, 1'b1);

    // RD_LAT=3: two WAIT cycles per word
    clear_log();
    kick(1'b1, 9'd0, 9'd0, 9'd30, 9'd30, 2'b00);
    check("t6_read", read3, 1'b0);
    @(negedge clk);
    check("t6_wait1", {busy3, read3, write3, done3}, 4'b1110);
    @(negedge clk);
    check("t6_wait2", {busy3, read3, write3, done3}, 4'b1110);
    @(negedge clk);
    check("t6_exec", {busy3, read3, write3}, 3'b111);
    @(negedge clk);
    check("t6_write", write3, 1'b0);
    check("t6_wdata", wdata3, {32'd0, 32'd3});
    @(negedge clk);
    check("t6_done", done3, 1'b1);

    // Reset during EXEC aborts the run
    kick(1'b1, 9'd0, 9'd1, 9'd30, 9'd30, 2'b00);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_abort", {read3, write3, busy3, done3}, 4'b1100);
    rst = 1'b0;
    @(negedge clk);
    check("t6_post_abort", {read3, write3, busy3}, 3'b110);
    clear_log();
    kick(1'b1, 9'd0, 9'd1, 9'd31, 9'd31, 2'b00);
    wait_done(1'b1, cyc, ok);
    check("t6_fresh_done", ok, 1'b1);
    check("t6_fresh_latency", cyc, 10);
    @(negedge clk);
    check("t6_fresh_counts", {8'(rd_cnt), 8'(wr_cnt), 8'(done_cnt)}, {8'd2, 8'd1, 8'd1});
    check("t6_fresh_w0", {wlog_a[0], wlog_d[0]}, {9'd31, 32'd7, 32'd3});
    check("no_overlap", overlap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
